// File: rtl/updown_counter_pkg.sv
// Shared encodings for the decimal up/down counter block.
package updown_counter_pkg;

    localparam int unsigned COUNT_W = 14;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/updown_counter_core_tick.sv
// Count-rate prescaler: a 0..DIV-1 counter that pulses tick on its last value while enabled.
module count_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] Last = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == Last);

endmodule

// File: rtl/updown_counter_core.sv
// Decimal up/down counter with run/stop/clear control, feeding a 4-digit FND controller.
module updown_counter_core
    import updown_counter_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned TICK_HZ     = 10,
    parameter int unsigned MAX_COUNT   = 9999,
    parameter int unsigned BLINK_TICKS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run_stop,
    input  logic               i_clear,
    input  logic               i_mode,
    output logic [COUNT_W-1:0] o_count,
    output logic [3:0]         o_dot,
    output logic               o_mode,
    output logic               o_running,
    output logic               o_tick
);

    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [COUNT_W-1:0] MaxCnt    = COUNT_W'(MAX_COUNT);
    localparam logic [BW-1:0]      BlinkLast = BW'(BLINK_TICKS - 1);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               mode_q, mode_d;
    logic               tick_q, running_q, dot1_q, dot1_d;
    logic               tick;

    count_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == RUN),
        .clr   (state_q == CLEAR),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear has priority over run/stop while stopped; clear is ignored while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STOP: begin
                if (i_clear) begin
                    state_d = CLEAR;
                end else if (i_run_stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_run_stop) begin
                    state_d = STOP;
                end
            end
            CLEAR:   state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    // A tick uses the direction held before any coincident mode toggle.
    always_comb begin
        count_d     = count_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        if (state_q == CLEAR) begin
            count_d     = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else begin
            if (i_mode) begin
                mode_d = ~mode_q;
            end
            if (tick) begin
                if (mode_q == DIR_UP) begin
                    count_d = (count_q == MaxCnt) ? '0 : count_q + 1'b1;
                end else begin
                    count_d = (count_q == '0) ? MaxCnt : count_q - 1'b1;
                end
                if (blink_cnt_q == BlinkLast) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
        dot1_d = ~(phase_d & (state_d == RUN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode_q      <= DIR_UP;
            tick_q      <= 1'b0;
            running_q   <= 1'b0;
            dot1_q      <= 1'b1;
        end else begin
            count_q     <= count_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            tick_q      <= tick;
            running_q   <= (state_d == RUN);
            dot1_q      <= dot1_d;
        end
    end

    assign o_count   = count_q;
    assign o_mode    = mode_q;
    assign o_tick    = tick_q;
    assign o_running = running_q;
    assign o_dot     = {2'b11, dot1_q, 1'b1};

endmodule

// File: tb/tb_updown_counter_core.sv
// Randomized and directed bench for updown_counter_core against a cycle-level behavioural model.
module tb_updown_counter_core;

    localparam int DIV  = 10;
    localparam int MAXC = 9999;
    localparam int BT   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_run_stop = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_mode = 1'b0;
    logic [13:0] o_count;
    logic [3:0]  o_dot;
    logic        o_mode;
    logic        o_running;
    logic        o_tick;

    int checks = 0;
    int failures = 0;

    // Model: 0 = stopped, 1 = running, 2 = clearing
    int m_state, m_presc, m_cnt, m_mode, m_bcnt, m_phase, m_tick;

    updown_counter_core #(
        .CLK_FREQ    (100),
        .TICK_HZ     (10),
        .MAX_COUNT   (MAXC),
        .BLINK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run_stop (i_run_stop),
        .i_clear    (i_clear),
        .i_mode     (i_mode),
        .o_count    (o_count),
        .o_dot      (o_dot),
        .o_mode     (o_mode),
        .o_running  (o_running),
        .o_tick     (o_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_cnt = 0; m_mode = 0;
        m_bcnt = 0; m_phase = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit rs, input bit cl, input bit md);
        int tk;
        tk = (m_state == 1 && m_presc == DIV - 1) ? 1 : 0;
        if (tk != 0) begin
            m_cnt = (m_mode == 0) ? (m_cnt + 1) % (MAXC + 1) : (m_cnt + MAXC) % (MAXC + 1);
            m_bcnt = (m_bcnt + 1) % BT;
            if (m_bcnt == 0) m_phase = 1 - m_phase;
        end
        if (m_state == 1) m_presc = (m_presc + 1) % DIV;
        if (m_state != 2 && md) m_mode = 1 - m_mode;
        if (m_state == 2) begin
            m_cnt = 0; m_presc = 0; m_bcnt = 0; m_phase = 0;
        end
        case (m_state)
            0:       m_state = cl ? 2 : (rs ? 1 : 0);
            1:       m_state = rs ? 0 : 1;
            default: m_state = 0;
        endcase
        m_tick = tk;
    endtask

    task automatic check_all();
        int exp_dot;
        exp_dot = (m_state == 1 && m_phase == 1) ? 4'b1101 : 4'b1111;
        check_eq("count", 32'(o_count), m_cnt);
        check_eq("tick", 32'(o_tick), m_tick);
        check_eq("running", 32'(o_running), (m_state == 1) ? 1 : 0);
        check_eq("mode", 32'(o_mode), m_mode);
        check_eq("dot", 32'(o_dot), exp_dot);
    endtask

    task automatic step(input bit rs, input bit cl, input bit md);
        @(negedge clk);
        i_run_stop = rs; i_clear = cl; i_mode = md;
        @(posedge clk);
        model_step(rs, cl, md);
        #1;
        i_run_stop = 1'b0; i_clear = 1'b0; i_mode = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Steps idle cycles until o_tick is seen; n is the cycle count, 50 on timeout.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end while (!o_tick && n < 50);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;
        repeat (100) step(1'b0, 1'b0, 1'b0);

        // Start counting up; first tick DIV cycles after RUN is visible.
        step(1'b1, 1'b0, 1'b0);
        check_eq("run_on", 32'(o_running), 1);
        wait_tick(n);
        check_eq("first_tick_lat", n, 10);
        check_eq("first_count", 32'(o_count), 1);
        repeat (4) wait_tick(n);
        check_eq("count5", 32'(o_count), 5);
        check_eq("dot_lit", 32'(o_dot), 4'b1101);

        // Clear ignored while running, then stop freezes, then clear zeroes.
        step(1'b0, 1'b1, 1'b0);
        wait_tick(n);
        check_eq("clr_ignored", 32'(o_count), 6);
        step(1'b1, 1'b0, 1'b0);
        check_eq("stop_dot", 32'(o_dot), 4'b1111);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check_eq("frozen", 32'(o_count), 6);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("cleared", 32'(o_count), 0);
        check_eq("clr_stop", 32'(o_running), 0);

        // Clear and run_stop together: clear wins.
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_eq("both_cnt", 32'(o_count), 0);
        check_eq("both_run", 32'(o_running), 0);

        // Down from 0 wraps to MAX, then up from MAX wraps to 0.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        check_eq("wrap_down", 32'(o_count), MAXC);
        step(1'b0, 1'b0, 1'b1);
        wait_tick(n);
        check_eq("wrap_up", 32'(o_count), 0);

        // Stop with prescaler at 6, then resume: 4 cycles to the next tick.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        wait_tick(n);
        check_eq("resume_lat", n, 4);

        // Mode toggle coincident with the tick at count 5 uses the old direction.
        for (int k = 0; k < 20 && o_count != 14'd5; k++) wait_tick(n);
        check_eq("pre5", 32'(o_count), 5);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("coinc_cnt", 32'(o_count), 6);
        check_eq("coinc_tick", 32'(o_tick), 1);
        wait_tick(n);
        check_eq("after_coinc", 32'(o_count), 5);
        check_eq("after_lat", n, 10);

        // Random pulses with occasional asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(1499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(39) == 0, $urandom_range(29) == 0, $urandom_range(24) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
